gray_seq_checker: RTL and testbench

Downstream monitor for the gray code counter: samples the counter's gray output, decodes it to binary, and checks that every accepted sample is either a hold or a single +1 step modulo 2^WIDTH. It acquires lock after a run of good steps, then flags, counts, and recovers from sequence violations. Checker outputs feed status/debug logic and the verification scoreboard.

---
 rtl/gray_seq_checker.sv | 126 ++++++++++++
 tb/tb_gray_seq_checker.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/gray_seq_checker.sv
// Gray-sequence monitor: decodes sampled gray code, tracks lock on a +1/hold sequence,
// and flags, counts and recovers from sequence violations.
module gray_seq_checker #(
    parameter int unsigned WIDTH     = 3,
    parameter int unsigned SYNC_LEN  = 2,
    parameter int unsigned ERR_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [WIDTH-1:0]     gray_in,
    input  logic                 valid_in,
    input  logic                 clear_err,
    output logic [WIDTH-1:0]     bin_out,
    output logic                 bin_valid,
    output logic                 locked,
    output logic                 step_err,
    output logic                 wrap_pulse,
    output logic [ERR_CNT_W-1:0] err_count
);

    localparam int unsigned CNT_W = $clog2(SYNC_LEN + 1);
    localparam logic [CNT_W-1:0] SYNC_TARGET = CNT_W'(SYNC_LEN);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SYNC   = 2'd1;
    localparam logic [1:0] ST_LOCKED = 2'd2;

    logic [1:0]           state_q, state_d;
    logic [CNT_W-1:0]     good_cnt_q, good_cnt_d;
    logic [WIDTH-1:0]     prev_q;
    logic [ERR_CNT_W-1:0] err_q, err_d;
    logic [WIDTH-1:0]     dec;
    logic [WIDTH-1:0]     prev_inc;
    logic                 is_hold, is_good, is_bad;
    logic                 counted_bad, wrap_d;

    // Each binary bit is the XOR of all gray bits at or above it.
    always_comb begin
        dec = '0;
        for (int i = 0; i < int'(WIDTH); i++) begin
            dec[i] = ^(gray_in >> i);
        end
    end

    assign prev_inc = prev_q + WIDTH'(1);
    assign is_hold  = (dec == prev_q);
    assign is_good  = (dec == prev_inc);
    assign is_bad   = !is_hold && !is_good;

    always_comb begin
        state_d     = state_q;
        good_cnt_d  = good_cnt_q;
        counted_bad = 1'b0;
        wrap_d      = 1'b0;
        if (valid_in) begin
            case (state_q)
                ST_IDLE: begin
                    state_d    = ST_SYNC;
                    good_cnt_d = '0;
                end
                ST_SYNC: begin
                    if (is_good) begin
                        good_cnt_d = good_cnt_q + CNT_W'(1);
                        if (good_cnt_d == SYNC_TARGET) begin
                            state_d = ST_LOCKED;
                        end
                    end else if (is_bad) begin
                        good_cnt_d = '0;
                    end
                end
                ST_LOCKED: begin
                    if (is_bad) begin
                        counted_bad = 1'b1;
                        state_d     = ST_SYNC;
                        good_cnt_d  = '0;
                    end else if (is_good && (prev_q == '1)) begin
                        wrap_d = 1'b1;
                    end
                end
                default: begin
                    state_d    = ST_IDLE;
                    good_cnt_d = '0;
                end
            endcase
        end
    end

    // A clear coinciding with a counted violation leaves exactly that one violation.
    always_comb begin
        err_d = err_q;
        if (clear_err) begin
            err_d = counted_bad ? ERR_CNT_W'(1) : '0;
        end else if (counted_bad && (err_q != '1)) begin
            err_d = err_q + ERR_CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            good_cnt_q <= '0;
            prev_q     <= '0;
            err_q      <= '0;
            bin_out    <= '0;
            bin_valid  <= 1'b0;
            locked     <= 1'b0;
            step_err   <= 1'b0;
            wrap_pulse <= 1'b0;
        end else begin
            state_q    <= state_d;
            good_cnt_q <= good_cnt_d;
            err_q      <= err_d;
            bin_valid  <= valid_in;
            locked     <= (state_d == ST_LOCKED);
            step_err   <= counted_bad;
            wrap_pulse <= wrap_d;
            if (valid_in) begin
                prev_q  <= dec;
                bin_out <= dec;
            end
        end
    end

    assign err_count = err_q;

endmodule

// File: tb/tb_gray_seq_checker.sv
// Randomized and directed bench for gray_seq_checker against a behavioural sequence model.
module tb_gray_seq_checker;

    localparam int W    = 3;
    localparam int SL   = 2;
    localparam int EW   = 2;
    localparam int MOD  = 1 << W;
    localparam int EMAX = (1 << EW) - 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [W-1:0]  gray_in = '0;
    logic          valid_in = 1'b0;
    logic          clear_err = 1'b0;
    logic [W-1:0]  bin_out;
    logic          bin_valid, locked, step_err, wrap_pulse;
    logic [EW-1:0] err_count;

    int total = 0;
    int bad = 0;

    // Model state: mode 0 = waiting for first sample, 1 = syncing, 2 = locked.
    int m_mode, m_prev, m_good;
    int e_bin, e_bv, e_locked, e_serr, e_wrap, e_err;

    gray_seq_checker #(
        .WIDTH     (W),
        .SYNC_LEN  (SL),
        .ERR_CNT_W (EW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .gray_in    (gray_in),
        .valid_in   (valid_in),
        .clear_err  (clear_err),
        .bin_out    (bin_out),
        .bin_valid  (bin_valid),
        .locked     (locked),
        .step_err   (step_err),
        .wrap_pulse (wrap_pulse),
        .err_count  (err_count)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] to_gray(input int b);
        int v;
        v = b % MOD;
        return W'(v ^ (v >> 1));
    endfunction

    function automatic int from_gray(input logic [W-1:0] g);
        int v, acc;
        v = int'(g);
        acc = 0;
        while (v != 0) begin
            acc = acc ^ v;
            v = v >> 1;
        end
        return acc;
    endfunction

    task automatic model_reset();
        m_mode = 0; m_prev = 0; m_good = 0;
        e_bin = 0; e_bv = 0; e_locked = 0; e_serr = 0; e_wrap = 0; e_err = 0;
    endtask

    task automatic model_edge(input logic v, input logic [W-1:0] g, input logic c);
        int  d;
        bit  counted;
        counted = 0;
        e_bv = int'(v); e_serr = 0; e_wrap = 0;
        if (v) begin
            d = from_gray(g);
            e_bin = d;
            if (m_mode == 0) begin
                m_mode = 1;
                m_good = 0;
            end else if (m_mode == 1) begin
                if (d == (m_prev + 1) % MOD) begin
                    m_good++;
                    if (m_good == SL) m_mode = 2;
                end else if (d != m_prev) begin
                    m_good = 0;
                end
            end else begin
                if (d != m_prev && d != (m_prev + 1) % MOD) begin
                    e_serr = 1; counted = 1; m_mode = 1; m_good = 0;
                end else if (d == 0 && m_prev == MOD - 1) begin
                    e_wrap = 1;
                end
            end
            m_prev = d;
        end
        if (c) e_err = counted ? 1 : 0;
        else if (counted && e_err < EMAX) e_err++;
        e_locked = (m_mode == 2) ? 1 : 0;
    endtask

    task automatic check_all();
        check_val("bin_out", int'(bin_out), e_bin);
        check_val("bin_valid", int'(bin_valid), e_bv);
        check_val("locked", int'(locked), e_locked);
        check_val("step_err", int'(step_err), e_serr);
        check_val("wrap_pulse", int'(wrap_pulse), e_wrap);
        check_val("err_count", int'(err_count), e_err);
    endtask

    task automatic step(input logic v, input logic [W-1:0] g, input logic c);
        valid_in = v; gray_in = g; clear_err = c;
        @(posedge clk);
        model_edge(v, g, c);
        #1;
        check_all();
    endtask

    task automatic step_bin(input int b, input logic c);
        step(1'b1, to_gray(b), c);
    endtask

    // From locked at m_prev: one violation then enough good steps to relock.
    task automatic violate_and_relock(input logic c);
        int p;
        p = (m_prev + 3) % MOD;
        step_bin(p, c);
        for (int k = 1; k <= SL; k++) step_bin(p + k, 1'b0);
    endtask

    initial begin
        int b;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all();
        rst_n = 1'b1;

        // Acquire lock on 000,001,011,010.
        step(1'b1, 3'b000, 1'b0);
        step(1'b1, 3'b001, 1'b0);
        step(1'b1, 3'b011, 1'b0);
        step(1'b1, 3'b010, 1'b0);
        check_val("lock_acquired", int'(locked), 1);
        // Run through the wrap: bins 4..7 then 0.
        for (int k = 4; k <= 8; k++) step_bin(k, 1'b0);
        // bin 1, 2, then a jump to 5 and relock via 6, 7.
        step_bin(1, 1'b0);
        step_bin(2, 1'b0);
        step(1'b1, 3'b111, 1'b0);
        check_val("err_after_jump", int'(err_count), 1);
        step(1'b1, 3'b101, 1'b0);
        step(1'b1, 3'b100, 1'b0);
        check_val("relocked", int'(locked), 1);
        // Hold, then idle with junk on gray_in.
        repeat (4) step(1'b1, 3'b100, 1'b0);
        repeat (3) step(1'b0, W'($urandom), 1'b0);
        // Saturate the error counter, then clear alongside a counted violation.
        repeat (5) violate_and_relock(1'b0);
        check_val("err_saturated", int'(err_count), EMAX);
        violate_and_relock(1'b1);
        check_val("clear_with_bad", int'(err_count), 1);
        violate_and_relock(1'b0);
        check_val("err_before_reset", int'(err_count), 2);

        // Asynchronous reset mid-cycle.
        valid_in = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        #2 rst_n = 1'b1;
        step_bin(5, 1'b0);
        step_bin(1, 1'b0);
        check_val("no_err_after_reset", int'(err_count), 0);

        // Random traffic biased towards legal steps.
        for (int n = 0; n < 400; n++) begin
            int r;
            r = $urandom_range(0, 19);
            if (r < 12)      b = m_prev + 1;
            else if (r < 16) b = m_prev;
            else             b = $urandom_range(0, MOD - 1);
            step(($urandom_range(0, 7) != 0), to_gray(b), ($urandom_range(0, 15) == 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
